dma_controller: RTL
===================

// Module: dma_controller
// PURPOSE
//   Cycle-stealing DMA engine: the consumer side of external_device. On a CPU command it
//   requests the bus (BR/BG), selects device blocks via offset and writes their 16-bit
//   words to data memory. Asserts dma_done on completion. Sits between CPU, memory port
//   and external_device.
// PARAMETERS
//   WORD_SIZE       16  memory word / address width
//   DEVICE_BIT_LEN   2  width of device offset bus
//   NUM_BLOCKS       3  device blocks available (offsets 0..NUM_BLOCKS-1)
//   WORDS_PER_BLOCK  4  words per device block (dev_data = WORDS_PER_BLOCK*WORD_SIZE)
// PORTS
//   clk         in   1       rising-edge clock
//   reset_n     in   1       synchronous, active-low reset
//   cmd_valid   in   1       one-cycle command strobe from CPU
//   cmd_addr    in   16      memory base address
//   cmd_count   in   2       blocks to transfer
//   BG          in   1       bus grant from CPU
//   BR          out  1       bus request
//   offset      out  2       block select to device
//   dev_data    in   64      block data from device
//   mem_write   out  1       memory write strobe
//   mem_addr    out  16      memory write address
//   mem_wdata   out  16      memory write data
//   mem_ack     in   1       memory write accepted (same cycle as mem_write)
//   dma_done    out  1       one-cycle completion pulse to CPU
// BEHAVIOUR
//   - Reset (reset_n=0 at clk edge): state IDLE, BR=0, mem_write=0, mem_addr=0,
//     mem_wdata=0, dma_done=0, offset=2'b11 (device idle, drives z). Reset mid-transfer
//     aborts immediately; no done pulse.
//   - offset=2'b11 in every state except LATCH/WRITE.
//   - States: IDLE -> REQ -> LATCH -> WRITE -> RELEASE -> REQ ... -> DONE -> IDLE.
//   - IDLE: cmd_valid latches base, count (clamped to NUM_BLOCKS), blk=0, word=0.
//     count=0 -> DONE next cycle, BR never asserted. cmd_valid outside IDLE ignored.
//   - REQ: BR=1; on BG=1 go LATCH.
//   - LATCH: offset=blk; dev_data registered at end of cycle (one cycle for device).
//   - WRITE: mem_write=1, mem_addr=base+WORDS_PER_BLOCK*blk+word,
//     mem_wdata=latched[WORD_SIZE*word +: WORD_SIZE] (word 0 = LSBs first).
//     Hold until mem_ack; then word++. After last word: blk++, word=0;
//     more blocks -> RELEASE, else DONE.
//   - BG drop during WRITE: current word completes on mem_ack, then REQ;
//     on re-grant resume at same blk/word (no re-LATCH, data retained).
//   - RELEASE: BR=0 exactly one cycle (CPU steals bus), then REQ.
//   - DONE: BR=0, dma_done=1 for one cycle, then IDLE.
//   - Address arithmetic modulo 2^WORD_SIZE (wraps 16'hFFFF -> 16'h0000).
//   - mem_ack while mem_write=0 ignored.
// CONFIGURATION
//   DMA_BURST_EN defined: bus held for whole transfer; after last word of a non-final
//     block go straight to LATCH for next blk, no RELEASE/REQ.
//   DMA_BURST_EN undefined: cycle-stealing per block as above (default).
// TESTING
//   - Reset: reset_n=0 two cycles -> BR=0, mem_write=0, dma_done=0, offset=2'b11.
//   - cmd_addr=16'h01F4, cmd_count=3, BG=BR after 1 cycle, mem_ack=1 -> 12 writes
//     to 0x01F4..0x01FF, word order LSB-first, BR low one cycle between blocks,
//     dma_done one pulse.
//   - cmd_count=0 -> dma_done pulse next cycle, BR stays 0, no writes.
//   - mem_ack delayed 3 cycles per word -> mem_addr/mem_wdata stable while waiting.
//   - BG dropped after 2nd word of block 1 -> words resume at base+6 on re-grant,
//     no duplicate/skipped word; cmd_addr=16'hFFFE wraps to 0x0000.
//   - With DMA_BURST_EN, count=3 -> BR held continuously for all 12 writes.

Source files
------------

// File: rtl/dma_controller.sv
`timescale 1ns / 1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : dma_controller                                               |
// | Description : Cycle-stealing DMA engine. On a CPU command it requests the   |
// |               bus (BR/BG), selects device blocks through offset, latches   |
// |               each block's words and writes them to data memory, then      |
// |               pulses dma_done.                                             |
// | Config      : DMA_BURST_EN - when defined the bus is held for the whole     |
// |               transfer (no RELEASE/REQ between blocks). Undefined by        |
// |               default: the bus is given back for one cycle per block.      |
// | Ports       : clk, reset_n (sync, active-low)                              |
// |               cmd_valid/cmd_addr/cmd_count : command from CPU              |
// |               BR (out) / BG (in)           : bus request / grant           |
// |               offset (out) / dev_data (in) : device block select / data    |
// |               mem_write/mem_addr/mem_wdata (out), mem_ack (in) : mem port  |
// |               dma_done (out)               : one-cycle completion pulse    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module dma_controller #(
  parameter int WORD_SIZE       = 16,
  parameter int DEVICE_BIT_LEN  = 2,
  parameter int NUM_BLOCKS      = 3,
  parameter int WORDS_PER_BLOCK = 4
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic                                 cmd_valid,
  input  logic [WORD_SIZE-1:0]                 cmd_addr,
  input  logic [DEVICE_BIT_LEN-1:0]            cmd_count,
  input  logic                                 BG,
  output logic                                 BR,
  output logic [DEVICE_BIT_LEN-1:0]            offset,
  input  logic [WORDS_PER_BLOCK*WORD_SIZE-1:0] dev_data,
  output logic                                 mem_write,
  output logic [WORD_SIZE-1:0]                 mem_addr,
  output logic [WORD_SIZE-1:0]                 mem_wdata,
  input  logic                                 mem_ack,
  output logic                                 dma_done
);

  localparam int WORD_W = (WORDS_PER_BLOCK > 1) ? $clog2(WORDS_PER_BLOCK) : 1;
  localparam int DATA_W = WORDS_PER_BLOCK * WORD_SIZE;
  localparam logic [DEVICE_BIT_LEN-1:0] MAX_COUNT    = DEVICE_BIT_LEN'(NUM_BLOCKS);
  localparam logic [DEVICE_BIT_LEN-1:0] OFFSET_IDLE  = '1;
  localparam logic [WORD_W-1:0]         LAST_WORD    = WORD_W'(WORDS_PER_BLOCK - 1);
  localparam logic [WORD_SIZE-1:0]      BLOCK_STRIDE = WORD_SIZE'(WORDS_PER_BLOCK);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQ     = 3'd1,
    S_LATCH   = 3'd2,
    S_WRITE   = 3'd3,
    S_RELEASE = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t                      state_q,   state_d;
  logic [WORD_SIZE-1:0]        base_q,    base_d;
  logic [DEVICE_BIT_LEN-1:0]   count_q,   count_d;
  logic [DEVICE_BIT_LEN-1:0]   blk_q,     blk_d;
  logic [WORD_W-1:0]           word_q,    word_d;
  logic [DATA_W-1:0]           data_q,    data_d;
  // Set once the current block is held in data_q, so a re-grant after a
  // mid-block BG drop resumes writing without re-reading the device.
  logic                        latched_q, latched_d;

  logic [DEVICE_BIT_LEN-1:0]   count_clamped;
  logic [DEVICE_BIT_LEN-1:0]   blk_inc;
  logic [WORD_SIZE-1:0]        word_addr;
  logic [WORD_SIZE-1:0]        word_data;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      base_q    <= '0;
      count_q   <= '0;
      blk_q     <= '0;
      word_q    <= '0;
      data_q    <= '0;
      latched_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      count_q   <= count_d;
      blk_q     <= blk_d;
      word_q    <= word_d;
      data_q    <= data_d;
      latched_q <= latched_d;
    end
  end

  // Address wraps naturally modulo 2^WORD_SIZE.
  assign count_clamped = (cmd_count > MAX_COUNT) ? MAX_COUNT : cmd_count;
  assign blk_inc       = blk_q + DEVICE_BIT_LEN'(1);
  assign word_addr     = base_q + (WORD_SIZE'(blk_q) * BLOCK_STRIDE) + WORD_SIZE'(word_q);
  assign word_data     = data_q[word_q*WORD_SIZE +: WORD_SIZE];

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    count_d   = count_q;
    blk_d     = blk_q;
    word_d    = word_q;
    data_d    = data_q;
    latched_d = latched_q;
    BR        = 1'b0;
    offset    = OFFSET_IDLE;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    dma_done  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          base_d    = cmd_addr;
          count_d   = count_clamped;
          blk_d     = '0;
          word_d    = '0;
          latched_d = 1'b0;
          state_d   = (count_clamped == '0) ? S_DONE : S_REQ;
        end
      end

      S_REQ: begin
        BR = 1'b1;
        if (BG) begin
          state_d = latched_q ? S_WRITE : S_LATCH;
        end
      end

      S_LATCH: begin
        BR        = 1'b1;
        offset    = blk_q;
        data_d    = dev_data;
        latched_d = 1'b1;
        state_d   = S_WRITE;
      end

      S_WRITE: begin
        BR        = 1'b1;
        offset    = blk_q;
        mem_write = 1'b1;
        mem_addr  = word_addr;
        mem_wdata = word_data;
        if (mem_ack) begin
          if (word_q == LAST_WORD) begin
            word_d    = '0;
            blk_d     = blk_inc;
            latched_d = 1'b0;
            if (blk_inc == count_q) begin
              state_d = S_DONE;
            end else begin
`ifdef DMA_BURST_EN
              // Keep the bus; only fall back to REQ if the CPU took it away.
              state_d = BG ? S_LATCH : S_REQ;
`else
              state_d = S_RELEASE;
`endif
            end
          end else begin
            word_d = word_q + WORD_W'(1);
            // Grant withdrawn: the acked word is finished, re-request.
            if (!BG) begin
              state_d = S_REQ;
            end
          end
        end
      end

      S_RELEASE: begin
        state_d = S_REQ;
      end

      S_DONE: begin
        dma_done = 1'b1;
        state_d  = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire
